// File: rtl/seg_pkg.sv
// Shared 7-segment definitions: segment bit positions, the blank pattern,
// the active-low decimal glyph table and the BCD engine state encoding.
package seg_pkg;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    localparam int SEG_A = 0;
    localparam int SEG_B = 1;
    localparam int SEG_C = 2;
    localparam int SEG_D = 3;
    localparam int SEG_E = 4;
    localparam int SEG_F = 5;
    localparam int SEG_G = 6;

    typedef enum logic [1:0] {
        BCD_IDLE  = 2'd0,
        BCD_SHIFT = 2'd1,
        BCD_DONE  = 2'd2
    } bcd_state_e;

    // Active-low glyphs, bit order g..a; non-decimal codes render blank.
    function automatic logic [6:0] seg_glyph(input logic [3:0] digit);
        logic [6:0] glyph;
        case (digit)
            4'd0:    glyph = 7'b1000000;
            4'd1:    glyph = 7'b1111001;
            4'd2:    glyph = 7'b0100100;
            4'd3:    glyph = 7'b0110000;
            4'd4:    glyph = 7'b0011001;
            4'd5:    glyph = 7'b0010010;
            4'd6:    glyph = 7'b0000010;
            4'd7:    glyph = 7'b1111000;
            4'd8:    glyph = 7'b0000000;
            4'd9:    glyph = 7'b0010000;
            default: glyph = SEG_BLANK;
        endcase
        return glyph;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter: one add-3/shift step per cycle.
// The BCD store only changes when a full conversion completes.
module bin2bcd_seq
    import seg_pkg::*;
#(
    parameter int IN_W   = 14,
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  abort,
    input  logic [IN_W-1:0]       bin,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd,
    output bcd_state_e            state
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int CNT_W = $clog2(IN_W + 1);

    bcd_state_e       state_q, state_next;
    logic [IN_W-1:0]  bin_sr_q;
    logic [BCD_W-1:0] work_q, work_adj, work_next, bcd_q;
    logic [CNT_W-1:0] cnt_q;
    logic             last_step;

    assign last_step = (cnt_q == CNT_W'(IN_W - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= BCD_IDLE;
        end else begin
            state_q <= state_next;
        end
    end

    always_comb begin
        state_next = state_q;
        case (state_q)
            BCD_IDLE:  if (start) state_next = BCD_SHIFT;
            BCD_SHIFT: if (last_step) state_next = BCD_DONE;
            BCD_DONE:  state_next = BCD_IDLE;
            default:   state_next = BCD_IDLE;
        endcase
        if (abort) state_next = BCD_IDLE;
    end

    always_comb begin
        work_adj = work_q;
        for (int d = 0; d < DIGITS; d++) begin
            if (work_q[4*d +: 4] >= 4'd5) work_adj[4*d +: 4] = work_q[4*d +: 4] + 4'd3;
        end
        work_next = {work_adj[BCD_W-2:0], bin_sr_q[IN_W-1]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bin_sr_q <= '0;
            work_q   <= '0;
            cnt_q    <= '0;
            bcd_q    <= '0;
        end else if (!abort) begin
            if (state_q == BCD_IDLE && start) begin
                bin_sr_q <= bin;
                work_q   <= '0;
                cnt_q    <= '0;
            end else if (state_q == BCD_SHIFT) begin
                bin_sr_q <= bin_sr_q << 1;
                work_q   <= work_next;
                cnt_q    <= cnt_q + CNT_W'(1);
                // Publish on the same edge that busy falls.
                if (last_step) bcd_q <= work_next;
            end
        end
    end

    assign busy  = (state_q == BCD_SHIFT);
    assign done  = (state_q == BCD_DONE);
    assign bcd   = bcd_q;
    assign state = state_q;

endmodule

// File: rtl/segment_display_ctrl.sv
// Registered 7-segment driver: gameplay playfield rendering or blanked,
// saturated, optionally blinking decimal score from a sequential BCD engine.
module segment_display_ctrl
    import seg_pkg::*;
#(
    parameter int NUM_DISP     = 6,
    parameter int SCORE_W      = 14,
    parameter int SCORE_DIGITS = 4,
    parameter int PLAYER_COL   = 4,
    parameter int BLINK_HALF   = 25_000_000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_DISP-1:0]   ceiling_bits,
    input  logic [NUM_DISP-1:0]   floor_bits,
    input  logic                  player_pos,
    input  logic                  show_score,
    input  logic                  blink_en,
    input  logic [SCORE_W-1:0]    score,
    output logic [7*NUM_DISP-1:0] disp_segs,
    output logic                  bcd_busy
);

    localparam int BCD_W   = 4 * SCORE_DIGITS;
    localparam int BLINK_W = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
    localparam logic [SCORE_W-1:0] SCORE_MAX = SCORE_W'(10**SCORE_DIGITS - 1);

    logic                  show_q;
    logic [SCORE_W-1:0]    cap_q;
    logic                  shown_q;
    logic [BLINK_W-1:0]    blink_cnt_q;
    logic                  blink_on_q;
    logic [7*NUM_DISP-1:0] segs_q, segs_next;

    logic                  conv_start, conv_abort, conv_busy, conv_done;
    logic [BCD_W-1:0]      conv_bcd;
    bcd_state_e            conv_state;
    logic [SCORE_W-1:0]    score_clamped;
    logic                  score_valid;
    logic                  nz_seen;
    logic [3:0]            digit;
    logic [6:0]            seg;

    assign score_clamped = (score > SCORE_MAX) ? SCORE_MAX : score;
    assign conv_abort    = ~show_score;
    // A new conversion starts on entry to score mode, or when an idle engine sees a new score.
    assign conv_start    = show_score && (conv_state == BCD_IDLE) && (!show_q || (score != cap_q));
    assign score_valid   = shown_q || conv_done;

    bin2bcd_seq #(
        .IN_W   (SCORE_W),
        .DIGITS (SCORE_DIGITS)
    ) u_bin2bcd (
        .clk   (clk),
        .rst_n (rst_n),
        .start (conv_start),
        .abort (conv_abort),
        .bin   (score_clamped),
        .busy  (conv_busy),
        .done  (conv_done),
        .bcd   (conv_bcd),
        .state (conv_state)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            show_q      <= 1'b0;
            cap_q       <= '0;
            shown_q     <= 1'b0;
            blink_cnt_q <= '0;
            blink_on_q  <= 1'b1;
            segs_q      <= '1;
        end else begin
            show_q <= show_score;
            segs_q <= segs_next;
            if (conv_start) cap_q <= score;
            if (!show_score)    shown_q <= 1'b0;
            else if (conv_done) shown_q <= 1'b1;
            if (show_score && blink_en) begin
                if (blink_cnt_q == BLINK_W'(BLINK_HALF - 1)) begin
                    blink_cnt_q <= '0;
                    blink_on_q  <= ~blink_on_q;
                end else begin
                    blink_cnt_q <= blink_cnt_q + BLINK_W'(1);
                end
            end else if (!blink_en) begin
                blink_cnt_q <= '0;
                blink_on_q  <= 1'b1;
            end
        end
    end

    always_comb begin
        segs_next = '1;
        nz_seen   = 1'b0;
        digit     = 4'd0;
        seg       = SEG_BLANK;
        if (!show_score) begin
            for (int i = 0; i < NUM_DISP; i++) begin
                seg        = SEG_BLANK;
                seg[SEG_A] = ~ceiling_bits[i];
                seg[SEG_D] = ~floor_bits[i];
                if (i == PLAYER_COL) begin
                    seg[SEG_B] = ~player_pos;
                    seg[SEG_C] = player_pos;
                end
                segs_next[7*i +: 7] = seg;
            end
        end else if (score_valid && blink_on_q) begin
            // Scan from the most significant digit so leading zeros stay blank.
            for (int i = SCORE_DIGITS - 1; i >= 0; i--) begin
                digit = conv_bcd[4*i +: 4];
                if (digit != 4'd0 || i == 0) nz_seen = 1'b1;
                if (nz_seen) segs_next[7*i +: 7] = seg_glyph(digit);
            end
        end
    end

    assign disp_segs = segs_q;
    assign bcd_busy  = conv_busy;

endmodule

// File: tb/tb_segment_display_ctrl.sv
// Self-checking bench for segment_display_ctrl: gameplay rendering, score
// conversion timing, saturation/blanking, re-trigger, abort, blink and reset.
module tb_segment_display_ctrl;

    localparam int NUM_DISP   = 6;
    localparam int SCORE_W    = 14;
    localparam int BLINK_HALF = 4;
    localparam int CONV_CYC   = 14;
    localparam logic [41:0] ALL_BLANK = '1;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [5:0]  ceiling_bits, floor_bits;
    logic        player_pos, show_score, blink_en;
    logic [13:0] score;
    logic [41:0] disp_segs;
    logic        bcd_busy;

    int n_checks = 0;
    int n_fail   = 0;

    segment_display_ctrl #(
        .NUM_DISP(NUM_DISP), .SCORE_W(SCORE_W), .SCORE_DIGITS(4),
        .PLAYER_COL(4), .BLINK_HALF(BLINK_HALF)
    ) dut (
        .clk(clk), .rst_n(rst_n), .ceiling_bits(ceiling_bits), .floor_bits(floor_bits),
        .player_pos(player_pos), .show_score(show_score), .blink_en(blink_en),
        .score(score), .disp_segs(disp_segs), .bcd_busy(bcd_busy)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] glyph(input int d);
        case (d)
            0: return 7'h40; 1: return 7'h79; 2: return 7'h24; 3: return 7'h30;
            4: return 7'h19; 5: return 7'h12; 6: return 7'h02; 7: return 7'h78;
            8: return 7'h00; default: return 7'h10;
        endcase
    endfunction

    // Decimal rendering from magnitude: digit k shows when k==0 or value >= 10^k.
    function automatic logic [41:0] score_model(input int val);
        logic [41:0] r;
        int v, p;
        r = '1;
        v = (val > 9999) ? 9999 : val;
        for (int k = 0; k < 4; k++) begin
            p = 10**k;
            if (k == 0 || v >= p) r[7*k +: 7] = glyph((v / p) % 10);
        end
        return r;
    endfunction

    function automatic logic [41:0] game_model(input logic [5:0] c, input logic [5:0] f, input logic p);
        logic [41:0] r;
        logic [6:0] s;
        r = '1;
        for (int i = 0; i < 6; i++) begin
            s = 7'h7F;
            if (c[i]) s[0] = 1'b0;
            if (f[i]) s[3] = 1'b0;
            if (i == 4) begin
                if (p) s[1] = 1'b0;
                else   s[2] = 1'b0;
            end
            r[7*i +: 7] = s;
        end
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Enter score mode from gameplay with the given score and count busy cycles.
    task automatic run_conversion(input int val, output int busy_cycles);
        show_score = 1'b0;
        tick();
        score      = SCORE_W'(val);
        show_score = 1'b1;
        tick();
        busy_cycles = 0;
        while (bcd_busy === 1'b1 && busy_cycles < 100) begin
            busy_cycles++;
            tick();
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; ceiling_bits = '0; floor_bits = '0; player_pos = 1'b0;
        show_score = 1'b0; blink_en = 1'b0; score = '0;
        tick(); tick();
        n_checks++;
        if (disp_segs !== ALL_BLANK) begin
            n_fail++; $display("FAIL reset_segs: got %h expected %h", disp_segs, ALL_BLANK);
        end
        n_checks++;
        if (bcd_busy !== 1'b0) begin
            n_fail++; $display("FAIL reset_busy: got %b expected 0", bcd_busy);
        end
        rst_n = 1'b1;
        tick();
        n_checks++;
        if (disp_segs !== game_model('0, '0, 1'b0)) begin
            n_fail++; $display("FAIL post_reset_game: got %h expected %h", disp_segs, game_model('0, '0, 1'b0));
        end
    endtask

    task automatic test_gameplay();
        logic [41:0] exp;
        ceiling_bits = 6'b100001; floor_bits = 6'b000110; player_pos = 1'b0; show_score = 1'b0;
        tick();
        exp = game_model(ceiling_bits, floor_bits, player_pos);
        n_checks++;
        if (disp_segs[6:0] !== 7'b1111110 || disp_segs[13:7] !== 7'b1110111 ||
            disp_segs[34:28] !== 7'b1111011 || disp_segs[41:35] !== 7'b1111110 || disp_segs !== exp) begin
            n_fail++; $display("FAIL game_directed: got %h expected %h", disp_segs, exp);
        end
        for (int n = 0; n < 16; n++) begin
            ceiling_bits = 6'($urandom);
            floor_bits   = 6'($urandom);
            player_pos   = 1'($urandom_range(0, 1));
            tick();
            exp = game_model(ceiling_bits, floor_bits, player_pos);
            n_checks++;
            if (disp_segs !== exp || bcd_busy !== 1'b0) begin
                n_fail++; $display("FAIL game_random: got %h busy %b expected %h busy 0", disp_segs, bcd_busy, exp);
            end
        end
    endtask

    task automatic test_score_values();
        int vals[12];
        int bc;
        vals = '{1234, 16383, 7, 0, 9999, 10000, 0, 0, 0, 0, 0, 0};
        for (int k = 6; k < 12; k++) vals[k] = $urandom_range(0, 16383);
        for (int k = 0; k < 12; k++) begin
            run_conversion(vals[k], bc);
            n_checks++;
            if (bc != CONV_CYC) begin
                n_fail++; $display("FAIL busy_len(%0d): got %0d expected %0d", vals[k], bc, CONV_CYC);
            end
            n_checks++;
            if (disp_segs !== ALL_BLANK) begin
                n_fail++; $display("FAIL blank_before_done(%0d): got %h expected %h", vals[k], disp_segs, ALL_BLANK);
            end
            tick();
            n_checks++;
            if (disp_segs !== score_model(vals[k])) begin
                n_fail++; $display("FAIL score_value(%0d): got %h expected %h", vals[k], disp_segs, score_model(vals[k]));
            end
        end
    endtask

    task automatic test_retrigger();
        int bc;
        show_score = 1'b0;
        tick();
        score = 14'd12; show_score = 1'b1;
        tick();
        for (int n = 0; n < 5; n++) tick();
        score = 14'd13;
        bc = 5;
        while (bcd_busy === 1'b1 && bc < 100) begin bc++; tick(); end
        n_checks++;
        if (bc != CONV_CYC) begin
            n_fail++; $display("FAIL retrig_first_len: got %0d expected %0d", bc, CONV_CYC);
        end
        tick();
        n_checks++;
        if (disp_segs !== score_model(12)) begin
            n_fail++; $display("FAIL retrig_shows_12: got %h expected %h", disp_segs, score_model(12));
        end
        tick();
        bc = 0;
        while (bcd_busy === 1'b1 && bc < 100) begin
            n_checks++;
            if (disp_segs !== score_model(12)) begin
                n_fail++; $display("FAIL retrig_partial: got %h expected %h", disp_segs, score_model(12));
            end
            bc++;
            tick();
        end
        n_checks++;
        if (bc != CONV_CYC) begin
            n_fail++; $display("FAIL retrig_second_len: got %0d expected %0d", bc, CONV_CYC);
        end
        tick();
        n_checks++;
        if (disp_segs !== score_model(13)) begin
            n_fail++; $display("FAIL retrig_shows_13: got %h expected %h", disp_segs, score_model(13));
        end
    endtask

    task automatic test_blink();
        int bc, prev_t, runs;
        logic lit_s[40];
        blink_en = 1'b0;
        run_conversion(1234, bc);
        tick();
        blink_en = 1'b1;
        for (int s = 0; s < 40; s++) begin
            tick();
            lit_s[s] = (disp_segs === score_model(1234));
            n_checks++;
            if (!lit_s[s] && disp_segs !== ALL_BLANK) begin
                n_fail++; $display("FAIL blink_pattern: got %h expected lit or blank", disp_segs);
            end
        end
        prev_t = -1;
        runs = 0;
        for (int s = 1; s < 40; s++) begin
            if (lit_s[s] != lit_s[s-1]) begin
                if (prev_t >= 0) begin
                    runs++;
                    n_checks++;
                    if (s - prev_t != BLINK_HALF) begin
                        n_fail++; $display("FAIL blink_run_len: got %0d expected %0d", s - prev_t, BLINK_HALF);
                    end
                end
                prev_t = s;
            end
        end
        n_checks++;
        if (runs < 6) begin
            n_fail++; $display("FAIL blink_runs: got %0d expected >= 6", runs);
        end
        blink_en = 1'b0;
        tick(); tick();
        for (int s = 0; s < 12; s++) begin
            n_checks++;
            if (disp_segs !== score_model(1234)) begin
                n_fail++; $display("FAIL blink_off_steady: got %h expected %h", disp_segs, score_model(1234));
            end
            tick();
        end
    endtask

    task automatic test_abort();
        int bc;
        show_score = 1'b0;
        tick();
        score = 14'd4321; show_score = 1'b1;
        tick();
        for (int n = 0; n < 4; n++) tick();
        show_score = 1'b0;
        ceiling_bits = 6'($urandom); floor_bits = 6'($urandom); player_pos = 1'($urandom_range(0, 1));
        tick();
        n_checks++;
        if (bcd_busy !== 1'b0 || disp_segs !== game_model(ceiling_bits, floor_bits, player_pos)) begin
            n_fail++; $display("FAIL abort_game: got %h busy %b expected %h busy 0",
                               disp_segs, bcd_busy, game_model(ceiling_bits, floor_bits, player_pos));
        end
        show_score = 1'b1;
        tick();
        n_checks++;
        if (bcd_busy !== 1'b1 || disp_segs !== ALL_BLANK) begin
            n_fail++; $display("FAIL abort_restart: got %h busy %b expected %h busy 1", disp_segs, bcd_busy, ALL_BLANK);
        end
        bc = 0;
        while (bcd_busy === 1'b1 && bc < 100) begin bc++; tick(); end
        tick();
        n_checks++;
        if (disp_segs !== score_model(4321)) begin
            n_fail++; $display("FAIL abort_then_score: got %h expected %h", disp_segs, score_model(4321));
        end
    endtask

    task automatic test_reset_mid();
        int bc;
        show_score = 1'b0;
        tick();
        score = 14'd555; show_score = 1'b1;
        tick();
        for (int n = 0; n < 3; n++) tick();
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (disp_segs !== ALL_BLANK || bcd_busy !== 1'b0) begin
            n_fail++; $display("FAIL async_reset: got %h busy %b expected %h busy 0", disp_segs, bcd_busy, ALL_BLANK);
        end
        show_score = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        tick();
        n_checks++;
        if (bcd_busy !== 1'b0 || disp_segs !== game_model(ceiling_bits, floor_bits, player_pos)) begin
            n_fail++; $display("FAIL reset_residue: got %h busy %b expected %h busy 0",
                               disp_segs, bcd_busy, game_model(ceiling_bits, floor_bits, player_pos));
        end
        run_conversion(555, bc);
        n_checks++;
        if (bc != CONV_CYC) begin
            n_fail++; $display("FAIL reset_conv_len: got %0d expected %0d", bc, CONV_CYC);
        end
        tick();
        n_checks++;
        if (disp_segs !== score_model(555)) begin
            n_fail++; $display("FAIL reset_conv_value: got %h expected %h", disp_segs, score_model(555));
        end
    endtask

    initial begin
        test_reset();
        test_gameplay();
        test_score_values();
        test_retrigger();
        test_blink();
        test_abort();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
